vend_sequencer: RTL
===================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 200, is the maximum number of cycles to wait for paper_ack or coin_ack.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 coin_valid  input  1  coin validator presents a coin.
REQ-005 coin_type  input  2  coin code: 01 nickel, 10 dime, 11 quarter, 00 unrecognised.
REQ-006 coin_ready  output  1  sequencer accepts a coin this cycle.
REQ-007 fsm_q, fsm_d, fsm_n  output  1 each  one-cycle coin pulses to the newspaper FSM.
REQ-008 fsm_r, fsm_n1, fsm_d1, fsm_d2  input  1 each  registered release and change outputs from the newspaper FSM.
REQ-009 paper_req  output  1  request paper release; held until paper_ack.
REQ-010 paper_ack  input  1  paper dispenser has completed the release.
REQ-011 coin_req  output  1  request one change coin; held until coin_ack.
REQ-012 coin_sel  output  2  change coin type: 01 nickel, 10 dime, 00 when coin_req is low.
REQ-013 coin_ack  input  1  change dispenser has ejected one coin.
REQ-014 reject  output  1  one-cycle pulse: an unrecognised coin was routed to the return chute.
REQ-015 busy  output  1  high in every state except IDLE and FAULT.
REQ-016 fault  output  1  sticky; a handshake timeout occurred.

Function
REQ-017 The block SHALL implement the states IDLE, ISSUE, CHECK, PAPER, CHANGE, GAP and FAULT.
REQ-018 coin_ready SHALL equal 1 only in IDLE, and a coin is accepted when coin_valid and coin_ready are both 1 at a rising edge.
REQ-019 Acceptance with coin_type 00 SHALL pulse reject for 1 cycle, issue no fsm_* pulse, and leave the state at IDLE.
REQ-020 Acceptance with a valid coin_type SHALL latch the code and enter ISSUE.
REQ-021 In ISSUE, exactly one of fsm_q/fsm_d/fsm_n SHALL be high for exactly 1 cycle, and the next state is CHECK.
REQ-022 In CHECK, the block SHALL sample fsm_r/fsm_n1/fsm_d1/fsm_d2, which are valid 1 cycle after the pulse edge.
REQ-023 In CHECK with fsm_r=0, the next state SHALL be IDLE and nothing is dispensed.
REQ-024 In CHECK with fsm_r=1, the block SHALL load dime_cnt = fsm_d1 + 2*fsm_d2 (2 bits) and nick_cnt = fsm_n1 (1 bit), then enter PAPER.
REQ-025 In PAPER, paper_req SHALL be held at 1 until paper_ack is sampled at 1.
REQ-026 On paper_ack, paper_req SHALL drop on the next cycle, and the next state is CHANGE if any count is nonzero, otherwise IDLE.
REQ-027 In CHANGE, coin_req SHALL be 1, and coin_sel SHALL be 10 while dime_cnt>0, otherwise 01, so that dimes are always dispensed first.
REQ-028 On coin_ack in CHANGE, the selected count SHALL decrement by 1 and the block SHALL enter GAP for 1 cycle with coin_req=0.
REQ-029 From GAP, the next state SHALL be CHANGE if any count remains, otherwise IDLE.
REQ-030 Counts SHALL never underflow, and an ack received while the corresponding req is low SHALL be ignored.
REQ-031 A wait counter SHALL clear on entry to PAPER and to CHANGE, increment each cycle without the ack, and never wrap.
REQ-032 When the wait counter reaches TIMEOUT, the block SHALL enter FAULT with fault=1 and all req outputs at 0.
REQ-033 In FAULT, coin_ready=0 and the block SHALL remain there until reset.
REQ-034 coin_valid in any state other than IDLE SHALL be ignored, with the coin held upstream by coin_ready=0.
REQ-035 An ack arriving in the same cycle the wait counter reaches TIMEOUT SHALL take priority over the timeout.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, clear all counters, and drive every output to 0 except coin_ready, which is 1 once rst_n=1.
REQ-037 Reset asserted mid-dispense SHALL abandon remaining change with no further req, and the newspaper FSM is not resynchronised by this block.
REQ-038 The first accepted coin after rst_n deasserts SHALL be processed normally.

Verification
REQ-039 Nickel, nickel, dime, dime (total 30) with acks after 3 cycles -> fsm_n, fsm_n, fsm_d pulses with no release, then fsm_d, paper_req, and no coin_req.
REQ-040 Quarter then quarter -> paper_req, then coin_sel=10 twice with a 1-cycle GAP between, then IDLE.
REQ-041 Dime, dime, quarter (total 45) -> paper, then dime, dime, then coin_sel=01 nickel, in that order.
REQ-042 coin_type=00 -> reject pulse of 1 cycle, no fsm_* pulse, and coin_ready stays 1.
REQ-043 paper_ack never asserted -> fault=1 exactly TIMEOUT cycles after entering PAPER, and all reqs are 0.
REQ-044 rst_n pulsed low during CHANGE -> coin_req=0 asynchronously and the state returns to IDLE.

Source files
------------

// File: rtl/vend_sequencer.sv
// Coin-to-newspaper sequencer: forwards accepted coins to the newspaper FSM as pulses,
// then handshakes paper release and change dispensing (dimes before nickels).
module vend_sequencer #(
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_ready,
    output logic       fsm_q,
    output logic       fsm_d,
    output logic       fsm_n,
    input  logic       fsm_r,
    input  logic       fsm_n1,
    input  logic       fsm_d1,
    input  logic       fsm_d2,
    output logic       paper_req,
    input  logic       paper_ack,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    input  logic       coin_ack,
    output logic       reject,
    output logic       busy,
    output logic       fault
);

    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CHECK,
        PAPER,
        CHANGE,
        GAP,
        FAULT
    } state_t;

    state_t        state;
    logic [1:0]    dime_cnt;
    logic          nick_cnt;
    logic [WW-1:0] wait_cnt;

    logic change_left;
    logic wait_expiring;

    assign change_left   = (dime_cnt != 2'd0) || nick_cnt;
    assign wait_expiring = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dime_cnt   <= 2'd0;
            nick_cnt   <= 1'b0;
            wait_cnt   <= '0;
            coin_ready <= 1'b0;
            fsm_q      <= 1'b0;
            fsm_d      <= 1'b0;
            fsm_n      <= 1'b0;
            paper_req  <= 1'b0;
            coin_req   <= 1'b0;
            coin_sel   <= 2'b00;
            reject     <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            fsm_q  <= 1'b0;
            fsm_d  <= 1'b0;
            fsm_n  <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    coin_ready <= 1'b1;
                    busy       <= 1'b0;
                    if (coin_valid && coin_ready) begin
                        if (coin_type == 2'b00) begin
                            reject <= 1'b1;
                        end else begin
                            fsm_q      <= (coin_type == 2'b11);
                            fsm_d      <= (coin_type == 2'b10);
                            fsm_n      <= (coin_type == 2'b01);
                            coin_ready <= 1'b0;
                            busy       <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= CHECK;
                CHECK: begin
                    // Newspaper FSM outputs settle one cycle after the pulse it saw
                    if (fsm_r) begin
                        dime_cnt  <= {fsm_d2, 1'b0} + {1'b0, fsm_d1};
                        nick_cnt  <= fsm_n1;
                        wait_cnt  <= '0;
                        paper_req <= 1'b1;
                        state     <= PAPER;
                    end else begin
                        coin_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                PAPER: begin
                    if (paper_ack && paper_req) begin
                        paper_req <= 1'b0;
                        if (change_left) begin
                            coin_req <= 1'b1;
                            coin_sel <= (dime_cnt != 2'd0) ? 2'b10 : 2'b01;
                            wait_cnt <= '0;
                            state    <= CHANGE;
                        end else begin
                            coin_ready <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                        if (wait_expiring) begin
                            paper_req <= 1'b0;
                            busy      <= 1'b0;
                            fault     <= 1'b1;
                            state     <= FAULT;
                        end
                    end
                end
                CHANGE: begin
                    if (coin_ack && coin_req) begin
                        coin_req <= 1'b0;
                        coin_sel <= 2'b00;
                        if (coin_sel == 2'b10 && dime_cnt != 2'd0)
                            dime_cnt <= dime_cnt - 2'd1;
                        else if (nick_cnt)
                            nick_cnt <= 1'b0;
                        state <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                        if (wait_expiring) begin
                            coin_req <= 1'b0;
                            coin_sel <= 2'b00;
                            busy     <= 1'b0;
                            fault    <= 1'b1;
                            state    <= FAULT;
                        end
                    end
                end
                GAP: begin
                    if (change_left) begin
                        coin_req <= 1'b1;
                        coin_sel <= (dime_cnt != 2'd0) ? 2'b10 : 2'b01;
                        wait_cnt <= '0;
                        state    <= CHANGE;
                    end else begin
                        coin_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                FAULT: begin
                    // Sticky until reset: nothing is requested or accepted
                    coin_ready <= 1'b0;
                    paper_req  <= 1'b0;
                    coin_req   <= 1'b0;
                    coin_sel   <= 2'b00;
                    busy       <= 1'b0;
                    fault      <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
